// File: rtl/shifter_pkg.sv
// Shared op encoding for the pipelined barrel shifter.
package shifter_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_LSR = 2'b00;
    localparam op_t OP_LSL = 2'b01;
    localparam op_t OP_ASR = 2'b10;
    localparam op_t OP_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by 2**STAGE followed by its register slice.
// Carry/zero flag slices are present only when SHIFTER_PIPE_FLAGS_EN is defined.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  op_t              in_op,
    input  logic             in_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_PIPE_FLAGS_EN
    ,
    input  logic             in_carry,
    output logic             out_carry,
    output logic             out_zero
`endif
);

    localparam int SH = 2 ** STAGE;

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        if (in_en) begin
            case (in_op)
                OP_LSR:  shifted = in_data >> SH;
                OP_LSL:  shifted = in_data << SH;
                OP_ASR:  shifted = $signed(in_data) >>> SH;
                default: shifted = {in_data[SH-1:0], in_data[WIDTH-1:SH]};
            endcase
        end
    end

`ifdef SHIFTER_PIPE_FLAGS_EN
    logic carry_next;

    // The highest applied stage wins: it sees the last bit leaving the word.
    always_comb begin
        carry_next = in_carry;
        if (in_en) begin
            if (in_op == OP_LSL) begin
                carry_next = in_data[WIDTH-SH];
            end else begin
                carry_next = in_data[SH-1];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef SHIFTER_PIPE_FLAGS_EN
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
`endif
        end else if (!hold) begin
            out_valid <= in_valid;
            out_data  <= shifted;
`ifdef SHIFTER_PIPE_FLAGS_EN
            out_carry <= carry_next;
            out_zero  <= (shifted == '0);
`endif
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (LSR/LSL/ASR/ROR), one stage per shift-amount bit, global stall.
// Define SHIFTER_PIPE_FLAGS_EN to add the pipelined flag_z / flag_c outputs.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         d_in,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  op_t                      op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         d_out
`ifdef SHIFTER_PIPE_FLAGS_EN
    ,
    output logic                     flag_z,
    output logic                     flag_c
`endif
);

    localparam int SHW = $clog2(WIDTH);

    logic             stall;
    logic             valid_q [SHW];
    logic [WIDTH-1:0] data_q  [SHW];
    op_t              op_q    [SHW-1];
    logic [SHW-1:0]   shamt_q [SHW-1];
`ifdef SHIFTER_PIPE_FLAGS_EN
    logic             carry_q [SHW];
    logic             zero_q  [SHW];
`endif

    assign stall    = out_valid && !out_ready;
    assign in_ready = !out_valid || out_ready;

    // Op and shift amount ride alongside the data into every later stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < SHW - 1; j++) begin
                op_q[j]    <= OP_LSR;
                shamt_q[j] <= '0;
            end
        end else if (!stall) begin
            op_q[0]    <= op;
            shamt_q[0] <= shamt;
            for (int j = 1; j < SHW - 1; j++) begin
                op_q[j]    <= op_q[j-1];
                shamt_q[j] <= shamt_q[j-1];
            end
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic             stg_valid;
        logic [WIDTH-1:0] stg_data;
        op_t              stg_op;
        logic             stg_en;
`ifdef SHIFTER_PIPE_FLAGS_EN
        logic             stg_carry;
`endif

        if (k == 0) begin : g_src
            assign stg_valid = in_valid && in_ready;
            assign stg_data  = d_in;
            assign stg_op    = op;
            assign stg_en    = shamt[0];
`ifdef SHIFTER_PIPE_FLAGS_EN
            assign stg_carry = 1'b0;
`endif
        end else begin : g_src
            assign stg_valid = valid_q[k-1];
            assign stg_data  = data_q[k-1];
            assign stg_op    = op_q[k-1];
            assign stg_en    = shamt_q[k-1][k];
`ifdef SHIFTER_PIPE_FLAGS_EN
            assign stg_carry = carry_q[k-1];
`endif
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .STAGE (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .hold      (stall),
            .in_valid  (stg_valid),
            .in_data   (stg_data),
            .in_op     (stg_op),
            .in_en     (stg_en),
            .out_valid (valid_q[k]),
            .out_data  (data_q[k])
`ifdef SHIFTER_PIPE_FLAGS_EN
            ,
            .in_carry  (stg_carry),
            .out_carry (carry_q[k]),
            .out_zero  (zero_q[k])
`endif
        );
    end

    assign out_valid = valid_q[SHW-1];
    assign d_out     = data_q[SHW-1];
`ifdef SHIFTER_PIPE_FLAGS_EN
    assign flag_c    = carry_q[SHW-1];
    assign flag_z    = zero_q[SHW-1];
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe at WIDTH=8: directed tables plus random
// handshake traffic checked against a queue-based arithmetic reference model.
module tb_shifter_pipe;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic [SHW-1:0]   shamt;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d_out;
`ifdef SHIFTER_PIPE_FLAGS_EN
    logic             flag_z;
    logic             flag_c;
`endif

    shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in      (d_in),
        .shamt     (shamt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out)
`ifdef SHIFTER_PIPE_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_c    (flag_c)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       z;
        int         t;
    } beat_t;

    beat_t      model[$];
    beat_t      seen[$];
    logic [7:0] tbl_d[$];
    logic [2:0] tbl_s[$];
    logic [1:0] tbl_o[$];

    int         n_vec = 0;
    int         n_bad = 0;
    int         cycle = 0;
    int         obs_t = 0;
    logic       obs_valid, obs_ready, obs_c, obs_z, consumed, accepted;
    logic [7:0] obs_data;

    // Expected result from the mode rules using double-width arithmetic.
    function automatic beat_t ref_beat(input logic [7:0] d, input logic [2:0] s,
                                       input logic [1:0] o, input int t);
        beat_t       b;
        logic [15:0] w;
        int          n;
        n = int'(s);
        case (o)
            2'b00:   w = {8'h00, d} >> n;
            2'b01:   w = {8'h00, d} << n;
            2'b10:   w = {{8{d[7]}}, d} >> n;
            default: w = {d, d} >> n;
        endcase
        b.d = w[7:0];
        if (n == 0)          b.c = 1'b0;
        else if (o == 2'b01) b.c = d[8 - n];
        else if (o == 2'b11) b.c = b.d[7];
        else                 b.c = d[n - 1];
        b.z = (b.d == 8'h00);
        b.t = t;
        return b;
    endfunction

    // One clock: drive at negedge, observe 1ns later, record handshakes.
    task automatic step(input logic rst, input logic iv, input logic [7:0] d,
                        input logic [2:0] s, input logic [1:0] o, input logic ordy);
        reset = rst; in_valid = iv; d_in = d; shamt = s; op = o; out_ready = ordy;
        #1;
        obs_valid = out_valid;
        obs_ready = in_ready;
        obs_data  = d_out;
`ifdef SHIFTER_PIPE_FLAGS_EN
        obs_c = flag_c;
        obs_z = flag_z;
`else
        obs_c = 1'b0;
        obs_z = 1'b0;
`endif
        obs_t    = cycle;
        accepted = iv && in_ready && !rst;
        consumed = out_valid && ordy && !rst;
        if (accepted) model.push_back(ref_beat(d, s, o, cycle));
        @(posedge clk);
        if (rst) model.delete();
        @(negedge clk);
        cycle++;
    endtask

    // Streams the table with out_ready high and collects what emerges plus its latency.
    task automatic run_table();
        int    n;
        beat_t e, r;
        n = tbl_d.size();
        seen.delete();
        for (int i = 0; i < n + SHW + 3; i++) begin
            if (i < n) step(1'b0, 1'b1, tbl_d[i], tbl_s[i], tbl_o[i], 1'b1);
            else       step(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
            if (consumed) begin
                r.d = obs_data; r.c = obs_c; r.z = obs_z;
                if (model.size() > 0) begin
                    e   = model.pop_front();
                    r.t = obs_t - e.t;
                end else begin
                    r.t = -1;
                end
                seen.push_back(r);
            end
        end
        tbl_d.delete(); tbl_s.delete(); tbl_o.delete();
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 8'($urandom), 3'($urandom), 2'($urandom), 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 8'($urandom), 3'($urandom), 2'($urandom), 1'b1);
            n_vec++;
            if (obs_valid !== 1'b0) begin
                n_bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", obs_valid);
            end
            n_vec++;
            if (obs_data !== 8'h00) begin
                n_bad++; $display("[TB] FAIL reset_d_out: got %h want 00", obs_data);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
            n_vec++;
            if (obs_ready !== 1'b1) begin
                n_bad++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", obs_ready);
            end
            n_vec++;
            if (obs_valid !== 1'b0) begin
                n_bad++; $display("[TB] FAIL post_reset_out_valid: got %b want 0", obs_valid);
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] want [4];
        want  = '{8'h2D, 8'hA0, 8'hED, 8'h96};
        tbl_d = '{8'hB4, 8'hB4, 8'hB4, 8'hB4};
        tbl_s = '{3'd2, 3'd3, 3'd2, 3'd3};
        tbl_o = '{2'b00, 2'b01, 2'b10, 2'b11};
        run_table();
        n_vec++;
        if (seen.size() != 4) begin
            n_bad++; $display("[TB] FAIL modes_count: got %0d want 4", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            n_vec++;
            if (seen[i].d !== want[i]) begin
                n_bad++; $display("[TB] FAIL modes_data[%0d]: got %h want %h", i, seen[i].d, want[i]);
            end
            n_vec++;
            if (seen[i].t != LAT) begin
                n_bad++; $display("[TB] FAIL modes_latency[%0d]: got %0d want %0d", i, seen[i].t, LAT);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] want [7];
        want  = '{8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h01, 8'h01};
        tbl_d = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        tbl_s = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};
        tbl_o = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b11};
        run_table();
        n_vec++;
        if (seen.size() != 7) begin
            n_bad++; $display("[TB] FAIL bound_count: got %0d want 7", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 7; i++) begin
            n_vec++;
            if (seen[i].d !== want[i]) begin
                n_bad++; $display("[TB] FAIL bound_data[%0d]: got %h want %h", i, seen[i].d, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int         sent = 0;
        int         got  = 0;
        logic [7:0] d, held;
        logic [2:0] s;
        logic [1:0] o;
        logic       ordy;
        logic       was_stalled = 1'b0;
        beat_t      e;
        d = 8'($urandom); s = 3'($urandom); o = 2'($urandom);
        held = 8'h00;
        for (int i = 0; i < 40 && got < 6; i++) begin
            ordy = !(i >= 5 && i < 9);
            step(1'b0, sent < 6, d, s, o, ordy);
            if (obs_valid && !ordy) begin
                n_vec++;
                if (obs_ready !== 1'b0) begin
                    n_bad++; $display("[TB] FAIL bp_in_ready: got %b want 0", obs_ready);
                end
                if (was_stalled) begin
                    n_vec++;
                    if (obs_data !== held) begin
                        n_bad++; $display("[TB] FAIL bp_hold: got %h want %h", obs_data, held);
                    end
                end
                held = obs_data;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (accepted) begin
                sent++;
                d = 8'($urandom); s = 3'($urandom); o = 2'($urandom);
            end
            if (consumed) begin
                got++;
                n_vec++;
                if (model.size() == 0) begin
                    n_bad++; $display("[TB] FAIL bp_extra: got %h want nothing", obs_data);
                end else begin
                    e = model.pop_front();
                    if (obs_data !== e.d) begin
                        n_bad++; $display("[TB] FAIL bp_data: got %h want %h", obs_data, e.d);
                    end
                end
            end
        end
        n_vec++;
        if (got != 6) begin
            n_bad++; $display("[TB] FAIL bp_count: got %0d want 6", got);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
            n_vec++;
            if (obs_valid !== 1'b0) begin
                n_bad++; $display("[TB] FAIL bp_duplicate: got out_valid %b want 0", obs_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 3'($urandom), 2'($urandom), 1'b0);
            n_vec++;
            if (accepted !== 1'b1) begin
                n_bad++; $display("[TB] FAIL mf_accept[%0d]: got %b want 1", i, accepted);
            end
        end
        step(1'b1, 1'b0, 8'h00, 3'd0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
            n_vec++;
            if (obs_valid !== 1'b0) begin
                n_bad++; $display("[TB] FAIL mf_leak: got out_valid %b data %h want 0", obs_valid, obs_data);
            end
        end
        tbl_d = '{8'h3C};
        tbl_s = '{3'd1};
        tbl_o = '{2'b01};
        run_table();
        n_vec++;
        if (seen.size() != 1) begin
            n_bad++; $display("[TB] FAIL mf_count: got %0d want 1", seen.size());
        end else begin
            n_vec++;
            if (seen[0].d !== 8'h78) begin
                n_bad++; $display("[TB] FAIL mf_data: got %h want 78", seen[0].d);
            end
            n_vec++;
            if (seen[0].t != LAT) begin
                n_bad++; $display("[TB] FAIL mf_latency: got %0d want %0d", seen[0].t, LAT);
            end
        end
    endtask

    task automatic test_random();
        int         sent = 0;
        logic       iv   = 1'b0;
        logic       ordy;
        logic [7:0] d = 8'h00;
        logic [2:0] s = 3'd0;
        logic [1:0] o = 2'd0;
        beat_t      e;
        for (int i = 0; i < 300 && (sent < 30 || model.size() > 0); i++) begin
            if (!iv && sent < 30 && $urandom_range(0, 3) != 0) begin
                iv = 1'b1;
                d = 8'($urandom); s = 3'($urandom); o = 2'($urandom);
            end
            ordy = (sent >= 30) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(1'b0, iv, d, s, o, ordy);
            if (accepted) begin
                sent++;
                iv = 1'b0;
            end
            if (consumed) begin
                n_vec++;
                if (model.size() == 0) begin
                    n_bad++; $display("[TB] FAIL rnd_extra: got %h want nothing", obs_data);
                end else begin
                    e = model.pop_front();
                    if (obs_data !== e.d) begin
                        n_bad++; $display("[TB] FAIL rnd_data: got %h want %h", obs_data, e.d);
                    end
`ifdef SHIFTER_PIPE_FLAGS_EN
                    n_vec++;
                    if (obs_c !== e.c || obs_z !== e.z) begin
                        n_bad++; $display("[TB] FAIL rnd_flags: got c=%b z=%b want c=%b z=%b", obs_c, obs_z, e.c, e.z);
                    end
`endif
                end
            end
        end
        n_vec++;
        if (model.size() != 0 || sent != 30) begin
            n_bad++; $display("[TB] FAIL rnd_drain: got %0d pending %0d sent want 0 pending 30 sent", model.size(), sent);
        end
    endtask

`ifdef SHIFTER_PIPE_FLAGS_EN
    task automatic test_flags();
        tbl_d = '{8'hB4, 8'hB4, 8'h01};
        tbl_s = '{3'd2, 3'd3, 3'd1};
        tbl_o = '{2'b00, 2'b01, 2'b00};
        run_table();
        n_vec++;
        if (seen.size() != 3) begin
            n_bad++; $display("[TB] FAIL flags_count: got %0d want 3", seen.size());
        end else begin
            n_vec++;
            if (seen[0].c !== 1'b0 || seen[0].z !== 1'b0) begin
                n_bad++; $display("[TB] FAIL flags_lsr2: got c=%b z=%b want c=0 z=0", seen[0].c, seen[0].z);
            end
            n_vec++;
            if (seen[1].c !== 1'b1) begin
                n_bad++; $display("[TB] FAIL flags_lsl3: got c=%b want 1", seen[1].c);
            end
            n_vec++;
            if (seen[2].d !== 8'h00 || seen[2].z !== 1'b1 || seen[2].c !== 1'b1) begin
                n_bad++; $display("[TB] FAIL flags_zero: got d=%h z=%b c=%b want d=00 z=1 c=1", seen[2].d, seen[2].z, seen[2].c);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; d_in = '0; shamt = '0; op = '0; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_modes();
        test_boundaries();
        test_backpressure();
        test_reset_midflight();
        test_random();
`ifdef SHIFTER_PIPE_FLAGS_EN
        test_flags();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
